// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Holds the FSM state and owner encodings, and the load/store type code widths
// shared with the LSU and data memory. Also holds the load code used for
// instruction fetches and a small state-classification helper.
package mem_arbiter_pkg;

    // Load and store type code widths, shared with the LSU and data memory
    localparam int LOAD_TYPE_W  = 3;
    localparam int STORE_TYPE_W = 2;

    // Width of the timeout counter; covers TIMEOUT up to 65535
    localparam int CNT_W = 16;

    // Load code presented to memory for instruction fetches (full word)
    localparam logic [LOAD_TYPE_W-1:0] LT_WORD = 3'b010;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Requester that currently owns the memory port
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // True while an access is outstanding on the memory port
    function automatic logic is_busy(input state_t s);
        return (s == ST_IF_BUSY) || (s == ST_D_BUSY);
    endfunction

endpackage

// File: rtl/mem_arbiter_timeout_counter.sv
// Timeout counter for the memory arbiter.
// Counts busy cycles of one access. o_expired is high in the busy cycle in which
// the TERMINAL-th cycle has elapsed without an acknowledge, so the arbiter can
// abandon the access on that same edge.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_clr      - synchronous clear (asserted on grant)
//   i_en       - count enable (asserted while busy)
//   o_expired  - terminal count reached in the current enabled cycle
module mem_arbiter_timeout_counter #(
    parameter int TERMINAL = 255,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    // Value held during the TERMINAL-th busy cycle (counter starts at zero)
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] r_count;

    // Busy-cycle counter: cleared on grant, advances once per busy cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_en) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = i_en & (r_count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port unified-memory arbiter between the fetch stage and the MEM stage.
// Data requests have fixed priority; an access runs grant -> busy -> RESP and
// the owner's done pulse is raised in RESP. Fetch results may be killed, and an
// access with no acknowledge after TIMEOUT busy cycles is abandoned with a
// sticky error and zero read data.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   if_req_i/if_addr_i/if_kill_i     - fetch request, address, kill pulse
//   if_rdata_o/if_done_o/if_stall_o  - fetch result, completion pulse, stall
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_load_type_i/d_store_type_i - data request
//   d_rdata_o/d_done_o/d_stall_o     - load result, completion pulse, stall
//   mem_*_o                          - memory request, held for the whole access
//   mem_rdata_i/mem_ack_i            - memory response
//   err_o                            - sticky timeout flag
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [ADDR_W-1:0]       if_addr_i,
    input  logic                    if_kill_i,
    output logic [DATA_W-1:0]       if_rdata_o,
    output logic                    if_done_o,
    output logic                    if_stall_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [ADDR_W-1:0]       d_addr_i,
    input  logic [DATA_W-1:0]       d_wdata_i,
    input  logic [LOAD_TYPE_W-1:0]  d_load_type_i,
    input  logic [STORE_TYPE_W-1:0] d_store_type_i,
    output logic [DATA_W-1:0]       d_rdata_o,
    output logic                    d_done_o,
    output logic                    d_stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    output logic [LOAD_TYPE_W-1:0]  mem_load_type_o,
    output logic [STORE_TYPE_W-1:0] mem_store_type_o,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    input  logic                    mem_ack_i,
    output logic                    err_o
);

    state_t                  r_state;
    owner_t                  r_owner;
    logic                    r_kill;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic [LOAD_TYPE_W-1:0]  r_mem_lt;
    logic [STORE_TYPE_W-1:0] r_mem_st;
    logic [DATA_W-1:0]       r_if_rdata;
    logic [DATA_W-1:0]       r_d_rdata;
    logic                    r_if_done;
    logic                    r_d_done;
    logic                    r_err;

    logic                    w_grant;
    logic                    w_busy;
    logic                    w_expired;
    logic                    w_if_done;
    logic [DATA_W-1:0]       w_resp_data;

    assign w_grant = (r_state == ST_IDLE) & (if_req_i | d_req_i);
    assign w_busy  = is_busy(r_state);

    // A timed-out access returns zero instead of whatever is on the bus
    assign w_resp_data = mem_ack_i ? mem_rdata_i : {DATA_W{1'b0}};

    mem_arbiter_timeout_counter #(
        .TERMINAL (TIMEOUT),
        .CNT_W    (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_grant),
        .i_en      (w_busy),
        .o_expired (w_expired)
    );

    // Arbitration FSM with registered memory-side and completion outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_mem_lt    <= {LOAD_TYPE_W{1'b0}};
            r_mem_st    <= {STORE_TYPE_W{1'b0}};
            r_if_rdata  <= {DATA_W{1'b0}};
            r_d_rdata   <= {DATA_W{1'b0}};
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_kill <= 1'b0;
                    if (d_req_i) begin
                        r_owner     <= OWN_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we_i;
                        r_mem_addr  <= d_addr_i;
                        r_mem_wdata <= d_wdata_i;
                        r_mem_lt    <= d_load_type_i;
                        r_mem_st    <= d_store_type_i;
                        r_state     <= ST_D_BUSY;
                    end else if (if_req_i) begin
                        r_owner    <= OWN_IF;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= if_addr_i;
                        r_mem_lt   <= LT_WORD;
                        r_state    <= ST_IF_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IF_BUSY, ST_D_BUSY: begin
                    // A kill seen in any busy cycle of a fetch, including the
                    // ack cycle, suppresses that fetch's done pulse
                    if ((r_owner == OWN_IF) && if_kill_i) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_ack_i || w_expired) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= ST_RESP;
                        if (!mem_ack_i) begin
                            r_err <= 1'b1;
                        end
                        if (r_owner == OWN_D) begin
                            r_d_rdata <= w_resp_data;
                            r_d_done  <= 1'b1;
                        end else begin
                            r_if_rdata <= w_resp_data;
                            r_if_done  <= ~(r_kill | if_kill_i);
                        end
                    end
                end
                ST_RESP: begin
                    r_kill  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // A kill arriving in the RESP cycle itself still masks the fetch done pulse
    assign w_if_done = r_if_done & ~if_kill_i;

    assign if_rdata_o       = r_if_rdata;
    assign if_done_o        = w_if_done;
    assign if_stall_o       = if_req_i & ~w_if_done;
    assign d_rdata_o        = r_d_rdata;
    assign d_done_o         = r_d_done;
    assign d_stall_o        = d_req_i & ~r_d_done;
    assign mem_req_o        = r_mem_req;
    assign mem_we_o         = r_mem_we;
    assign mem_addr_o       = r_mem_addr;
    assign mem_wdata_o      = r_mem_wdata;
    assign mem_load_type_o  = r_mem_lt;
    assign mem_store_type_o = r_mem_st;
    assign err_o            = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the stimulus thread pushes expected memory
// accesses and expected completions; a monitor pops and compares them whenever
// the DUT starts a memory access or pulses a done output.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i, if_kill_i, d_req_i, d_we_i, mem_ack_i;
    logic [AW-1:0] if_addr_i, d_addr_i;
    logic [DW-1:0] d_wdata_i, mem_rdata_i;
    logic [2:0]    d_load_type_i;
    logic [1:0]    d_store_type_i;
    logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
    logic          if_done_o, if_stall_o, d_done_o, d_stall_o;
    logic          mem_req_o, mem_we_o, err_o;
    logic [AW-1:0] mem_addr_o;
    logic [2:0]    mem_load_type_o;
    logic [1:0]    mem_store_type_o;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_rdata_o(if_rdata_o), .if_done_o(if_done_o), .if_stall_o(if_stall_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_load_type_i(d_load_type_i), .d_store_type_i(d_store_type_i),
        .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .d_stall_o(d_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_load_type_o(mem_load_type_o),
        .mem_store_type_o(mem_store_type_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .err_o(err_o)
    );

    // kind: 0 = fetch, 1 = load, 2 = store
    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [2:0]    lt;
        logic [1:0]    st;
        int            kind;
    } acc_t;

    typedef struct {
        logic          own_d;
        logic [DW-1:0] data;
    } resp_t;

    acc_t          acc_q[$];
    resp_t         resp_q[$];
    logic [DW-1:0] rd_q[$];

    int   errors = 0;
    int   checks = 0;
    logic mem_silent = 1'b0;
    int   mem_delay  = 2;
    int   mem_k      = 0;
    logic mon_prev_req = 1'b0;
    acc_t mon_held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_acc(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                           input logic [2:0] lt, input logic [1:0] st, input int kind);
        acc_t a;
        a.addr = addr; a.we = we; a.wdata = wdata; a.lt = lt; a.st = st; a.kind = kind;
        acc_q.push_back(a);
    endtask

    task automatic exp_resp(input logic own_d, input logic [DW-1:0] data);
        resp_t r;
        r.own_d = own_d; r.data = data;
        resp_q.push_back(r);
    endtask

    // Memory model: acks mem_delay cycles after mem_req_o rises, data from rd_q
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                mem_k     = 0;
            end else if (mem_req_o && !mem_silent && !rst) begin
                if (mem_k == mem_delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
                end else begin
                    mem_k++;
                end
            end else begin
                mem_k = 0;
            end
        end
    end

    // Monitor: checks memory accesses and completions against the scoreboard
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_req = 1'b0;
            end else begin
                if (mem_req_o && !mon_prev_req) begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_mem_req", 32'd1, 32'd0);
                    end else begin
                        mon_held = acc_q.pop_front();
                        chk("mem_addr", 32'(mem_addr_o), 32'(mon_held.addr));
                        chk("mem_we", 32'(mem_we_o), 32'(mon_held.we));
                        if (mon_held.kind == 1) chk("mem_load_type", 32'(mem_load_type_o), 32'(mon_held.lt));
                        if (mon_held.kind == 2) begin
                            chk("mem_wdata", mem_wdata_o, mon_held.wdata);
                            chk("mem_store_type", 32'(mem_store_type_o), 32'(mon_held.st));
                        end
                    end
                end else if (mem_req_o) begin
                    chk("mem_addr_stable", 32'(mem_addr_o), 32'(mon_held.addr));
                    chk("mem_we_stable", 32'(mem_we_o), 32'(mon_held.we));
                    if (mon_held.kind == 2) chk("mem_wdata_stable", mem_wdata_o, mon_held.wdata);
                end
                mon_prev_req = mem_req_o;
                if (if_done_o) begin
                    chk("if_stall_in_done", 32'(if_stall_o), 32'd0);
                    if (resp_q.size() == 0) begin
                        chk("unexpected_if_done", 32'd1, 32'd0);
                    end else begin
                        r = resp_q.pop_front();
                        chk("if_done_owner", 32'(r.own_d), 32'd0);
                        chk("if_rdata", if_rdata_o, r.data);
                    end
                end
                if (d_done_o) begin
                    chk("d_stall_in_done", 32'(d_stall_o), 32'd0);
                    if (resp_q.size() == 0) begin
                        chk("unexpected_d_done", 32'd1, 32'd0);
                    end else begin
                        r = resp_q.pop_front();
                        chk("d_done_owner", 32'(r.own_d), 32'd1);
                        chk("d_rdata", d_rdata_o, r.data);
                    end
                end
            end
        end
    end

    // Requester behaviour: drop a request on the edge after its done pulse
    task automatic tick();
        @(negedge clk);
        if (if_done_o) if_req_i = 1'b0;
        if (d_done_o)  d_req_i  = 1'b0;
    endtask

    task automatic wait_req(input string name, input int budget);
        int n = 0;
        while (!mem_req_o && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_req_seen"}, 32'(mem_req_o), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((resp_q.size() != 0 || acc_q.size() != 0 || mem_req_o || if_req_i || d_req_i)
               && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_complete"}, 32'(n < budget), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int n;
        int busy;
        rst = 1'b1;
        if_req_i = 1'b0; if_kill_i = 1'b0; if_addr_i = 10'h0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 10'h0; d_wdata_i = 32'h0;
        d_load_type_i = 3'b0; d_store_type_i = 2'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_if_done", 32'(if_done_o), 32'd0);
        chk("rst_d_done", 32'(d_done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_d_rdata", d_rdata_o, 32'h0);
        rst = 1'b0;
        tick();

        // Fetch only
        rd_q.push_back(32'h00500093);
        exp_acc(10'h010, 1'b0, 32'h0, 3'b0, 2'b0, 0);
        exp_resp(1'b0, 32'h00500093);
        if_addr_i = 10'h010; if_req_i = 1'b1;
        wait_req("fetch", 10);
        chk("fetch_if_stall_busy", 32'(if_stall_o), 32'd1);
        chk("fetch_d_stall_idle", 32'(d_stall_o), 32'd0);
        wait_idle("fetch", 30);

        // Collision: data wins, fetch follows
        rd_q.push_back(32'hCAFE0040);
        rd_q.push_back(32'h00A00113);
        exp_acc(10'h040, 1'b0, 32'h0, 3'b100, 2'b00, 1);
        exp_acc(10'h014, 1'b0, 32'h0, 3'b0, 2'b0, 0);
        exp_resp(1'b1, 32'hCAFE0040);
        exp_resp(1'b0, 32'h00A00113);
        d_addr_i = 10'h040; d_we_i = 1'b0; d_load_type_i = 3'b100; d_req_i = 1'b1;
        if_addr_i = 10'h014; if_req_i = 1'b1;
        wait_idle("collision", 60);
        chk("fetch_rdata_held", if_rdata_o, 32'h00A00113);

        // Store
        rd_q.push_back(32'h13579BDF);
        exp_acc(10'h0C8, 1'b1, 32'hDEADBEEF, 3'b0, 2'b10, 2);
        exp_resp(1'b1, 32'h13579BDF);
        d_addr_i = 10'h0C8; d_we_i = 1'b1; d_wdata_i = 32'hDEADBEEF; d_store_type_i = 2'b10;
        d_req_i = 1'b1;
        wait_idle("store", 30);
        d_we_i = 1'b0;
        chk("store_we_dropped", 32'(mem_we_o), 32'd0);

        // Kill: first fetch suppressed, new address fetched afterwards
        rd_q.push_back(32'h11111111);
        rd_q.push_back(32'h22222222);
        exp_acc(10'h020, 1'b0, 32'h0, 3'b0, 2'b0, 0);
        exp_acc(10'h024, 1'b0, 32'h0, 3'b0, 2'b0, 0);
        exp_resp(1'b0, 32'h22222222);
        if_addr_i = 10'h020; if_req_i = 1'b1;
        wait_req("kill", 10);
        if_kill_i = 1'b1;
        tick();
        if_kill_i = 1'b0;
        if_addr_i = 10'h024;
        wait_idle("kill", 60);

        // Timeout: silent memory, abandoned after 4 busy cycles
        chk("err_before_timeout", 32'(err_o), 32'd0);
        mem_silent = 1'b1;
        exp_acc(10'h100, 1'b0, 32'h0, 3'b010, 2'b00, 1);
        exp_resp(1'b1, 32'h0);
        d_addr_i = 10'h100; d_load_type_i = 3'b010; d_store_type_i = 2'b00; d_req_i = 1'b1;
        n = 0; busy = 0;
        while (!d_done_o && n < 30) begin
            tick();
            n++;
            if (mem_req_o) busy++;
        end
        chk("timeout_done_seen", 32'(d_done_o), 32'd1);
        chk("timeout_busy_cycles", 32'(busy), 32'd4);
        chk("timeout_err", 32'(err_o), 32'd1);
        mem_silent = 1'b0;
        wait_idle("timeout", 20);
        rd_q.push_back(32'h12345678);
        exp_acc(10'h030, 1'b0, 32'h0, 3'b0, 2'b0, 0);
        exp_resp(1'b0, 32'h12345678);
        if_addr_i = 10'h030; if_req_i = 1'b1;
        wait_idle("after_timeout", 30);
        chk("err_sticky", 32'(err_o), 32'd1);

        // Reset in the middle of a data access
        mem_silent = 1'b1;
        exp_acc(10'h080, 1'b0, 32'h0, 3'b001, 2'b00, 1);
        d_addr_i = 10'h080; d_load_type_i = 3'b001; d_req_i = 1'b1;
        wait_req("midrst", 10);
        tick();
        rst = 1'b1;
        d_req_i = 1'b0;
        tick();
        chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
        chk("midrst_d_done", 32'(d_done_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        mem_silent = 1'b0;
        repeat (6) tick();
        rd_q.push_back(32'hFFFFFFFF);
        exp_acc(10'h3FC, 1'b0, 32'h0, 3'b0, 2'b0, 0);
        exp_resp(1'b0, 32'hFFFFFFFF);
        if_addr_i = 10'h3FC; if_req_i = 1'b1;
        wait_idle("after_rst", 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port unified-memory controller for the pipelined core. Shares one memory port between the fetch stage (instruction requester) and the MEM stage (data requester).
- Sequences each access through a request/acknowledge FSM and returns read data to the owning requester.
- Drives per-requester stall signals into the pipeline.
- Supports killing an in-flight fetch on a taken branch or jump, and times out unresponsive memory.

Parameters:
- ADDR_W, 10, memory byte-address width.
- DATA_W, 32, data/instruction width.
- TIMEOUT, 255, cycles to wait for mem_ack_i before aborting; legal range 1..65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- if_req_i  input  1  fetch request; level, held until if_done_o.
- if_addr_i  input  ADDR_W  fetch address.
- if_kill_i  input  1  pulse; discard result of the outstanding fetch.
- if_rdata_o  output  DATA_W  fetched instruction.
- if_done_o  output  1  one-cycle fetch-complete pulse.
- if_stall_o  output  1  fetch stage must hold.
- d_req_i  input  1  data request; level, held until d_done_o.
- d_we_i  input  1  1 = store, 0 = load.
- d_addr_i  input  ADDR_W  data address.
- d_wdata_i  input  DATA_W  store data.
- d_load_type_i  input  3  load width/sign code.
- d_store_type_i  input  2  store width code.
- d_rdata_o  output  DATA_W  load result.
- d_done_o  output  1  one-cycle data-complete pulse.
- d_stall_o  output  1  MEM stage must hold.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_W  memory address.
- mem_wdata_o  output  DATA_W  memory write data.
- mem_load_type_o  output  3  forwarded load type.
- mem_store_type_o  output  2  forwarded store type.
- mem_rdata_i  input  DATA_W  memory read data; valid when mem_ack_i = 1.
- mem_ack_i  input  1  memory access complete.
- err_o  output  1  sticky timeout flag.

Behaviour:
- FSM states: IDLE, IF_BUSY, D_BUSY, RESP.
- IDLE:
  - d_req_i = 1 → latch d_* fields, go to D_BUSY.
  - else if_req_i = 1 → latch if_addr_i, go to IF_BUSY.
  - Data has fixed priority over fetch; no preemption once granted.
- IF_BUSY / D_BUSY:
  - mem_req_o = 1; all mem_* outputs driven from the latched fields, stable for the whole access.
  - mem_we_o = 1 only in D_BUSY with latched we = 1.
  - Timeout counter clears on grant and increments each busy cycle.
  - mem_ack_i = 1 → capture mem_rdata_i into the owner's rdata register, go to RESP.
  - Counter reaches TIMEOUT without ack → drop request, set err_o, rdata register = 0, go to RESP.
- RESP:
  - Assert owner's done_o for exactly one cycle, then go to IDLE.
  - Minimum access = 3 cycles (grant, ack, resp).
  - The requester updates or drops req on the edge after done_o, so IDLE samples the new request.
- Outputs:
  - mem_req_o = 0 in IDLE and RESP.
  - mem_addr_o, mem_wdata_o and the type fields hold their last value; don't-care when mem_req_o = 0.
  - if_rdata_o and d_rdata_o hold until overwritten by a later completion of the same owner.
- Kill:
  - if_kill_i = 1 while owner = fetch in IF_BUSY or RESP sets a kill flag, and if_done_o for that transaction is suppressed.
  - Kill in the same cycle as mem_ack_i is also suppressed.
  - The memory access still completes normally.
  - In IDLE or D_BUSY, kill is ignored.
  - The kill flag clears on entry to IDLE.
- Stalls (combinational):
  - if_stall_o = if_req_i & ~if_done_o.
  - d_stall_o = d_req_i & ~d_done_o.
- Simultaneous requests:
  - Both in IDLE → data wins; fetch is served on the next IDLE.
  - A request arriving while busy waits; it is never dropped.
- Reset:
  - All outputs 0, state IDLE, counter 0, kill flag 0, err_o 0.
  - Reset mid-access abandons the access; mem_req_o = 0 on the cycle after the reset edge; no done pulse.
- err_o clears only on rst.

Decomposition:
- defines.v holds:
  - FSM state encodings (2 bits).
  - Owner encoding (OWN_IF, OWN_D).
  - Load-type and store-type code widths, shared with the LSU and data memory.
- One sub-module, timeout_counter:
  - Sync clear, enable, parameterised terminal count, expired output.

Test Plan:
- Fetch only: if_req_i = 1, if_addr_i = 0x010, memory acks 2 cycles after mem_req_o → mem_addr_o = 0x010, if_done_o pulses once, if_rdata_o = mem_rdata_i (e.g. 0x00500093), if_stall_o = 0 in the done cycle.
- Collision: if_req_i and d_req_i (load, d_addr_i = 0x040) rise together → D_BUSY first with mem_addr_o = 0x040, d_done_o pulses; then fetch granted; if_done_o pulses later.
- Store: d_we_i = 1, d_wdata_i = 0xDEADBEEF, d_store_type_i = 2'b10 → mem_we_o = 1, mem_wdata_o = 0xDEADBEEF, mem_store_type_o = 2'b10 until ack; d_done_o pulses.
- Kill: if_kill_i pulse during IF_BUSY, ack arrives → no if_done_o; FSM returns to IDLE and the next fetch with a new address completes normally.
- Timeout: TIMEOUT = 4, no ack → mem_req_o drops after 4 busy cycles, err_o = 1 (sticky), done pulses with rdata = 0.
- Reset mid-access: assert rst during D_BUSY → next cycle mem_req_o = 0, d_done_o = 0, err_o = 0, FSM in IDLE.
